// File: rtl/sdr_tx_scheduler_if.sv
// Request/grant bundle between the packet sources and the UDP transmit scheduler.
// The master side drives requests and send_done; the scheduler (slave) returns
// the grant and status.
interface sdr_tx_scheduler_if #(
   parameter int NR = 4
);
   logic          run;
   logic          discovery_req;
   logic          cc_req;
   logic          mic_req;
   logic          wb_enable;
   logic          wb_req;
   logic [NR-1:0] ddc_req;
   logic          send_done;
   logic          grant_valid;
   logic [7:0]    grant_id;
   logic [NR-1:0] grant_ddc;
   logic          busy;
   logic          timeout_err;

   modport master (
      output run, discovery_req, cc_req, mic_req, wb_enable, wb_req, ddc_req, send_done,
      input  grant_valid, grant_id, grant_ddc, busy, timeout_err
   );

   modport slave (
      input  run, discovery_req, cc_req, mic_req, wb_enable, wb_req, ddc_req, send_done,
      output grant_valid, grant_id, grant_ddc, busy, timeout_err
   );
endinterface

// File: rtl/sdr_tx_scheduler.sv
// Transmit scheduler: picks which packet source owns the single UDP send engine.
// Fixed priority disc > CC > mic > WB > DDC, with DDCs served round-robin and
// WB slotted in once per DDC rotation. A grant is held until send_done, a
// watchdog expiry, or run dropping on a non-discovery grant.
module sdr_tx_scheduler #(
   parameter int NR         = 4,
   parameter int GAP_CYCLES = 2,
   parameter int TIMEOUT    = 65535
) (
   input logic              tx_clock,
   input logic              reset_n,
   sdr_tx_scheduler_if.slave bus
);

   localparam int PW = (NR > 1) ? $clog2(NR) : 1;
   localparam int SW = PW + 1;

   // Last GAP count value before returning to IDLE; GAP_CYCLES=0 still spends one cycle in GAP.
   localparam logic [3:0]  GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
   localparam logic [15:0] WD_LAST  = (TIMEOUT <= 1) ? 16'd0 : 16'(TIMEOUT - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;
   localparam logic [1:0] ST_GAP   = 2'd3;

   logic [1:0]    state_reg;
   logic          grant_valid_reg;
   logic [7:0]    grant_id_reg;
   logic [NR-1:0] grant_ddc_reg;
   logic          timeout_err_reg;
   logic [PW-1:0] rr_ptr_reg;
   logic          wb_eligible_reg;
   logic [3:0]    gap_cnt_reg;
   logic [15:0]   wd_cnt_reg;

   logic [PW-1:0] scan_idx [NR];
   logic          ddc_found;
   logic [PW-1:0] ddc_k;
   logic [PW-1:0] rr_ptr_next;
   logic          win_valid;
   logic          win_is_ddc;
   logic          win_is_wb;
   logic [7:0]    win_id;
   logic [NR-1:0] win_ddc;
   logic          run_abort;

   // Scan order for the DDC round-robin: rr_ptr, rr_ptr+1, ... modulo NR.
   genvar gi;
   generate
      for (gi = 0; gi < NR; gi++) begin : g_scan
         logic [SW-1:0] sum;
         assign sum          = {1'b0, rr_ptr_reg} + SW'(gi);
         assign scan_idx[gi] = (sum >= SW'(NR)) ? PW'(sum - SW'(NR)) : PW'(sum);
      end
   endgenerate

   // First requesting DDC in round-robin order starting at rr_ptr.
   always_comb begin
      ddc_found = 1'b0;
      ddc_k     = '0;
      for (int i = 0; i < NR; i++) begin
         if (!ddc_found && bus.ddc_req[scan_idx[i]]) begin
            ddc_found = 1'b1;
            ddc_k     = scan_idx[i];
         end
      end
      rr_ptr_next = (ddc_k == PW'(NR - 1)) ? '0 : ddc_k + PW'(1);
   end

   // Fixed-priority winner; only discovery may win while run is low.
   always_comb begin
      win_valid  = 1'b0;
      win_is_ddc = 1'b0;
      win_is_wb  = 1'b0;
      win_id     = 8'd0;
      win_ddc    = '0;
      if (bus.discovery_req) begin
         win_valid = 1'b1;
         win_id    = 8'd0;
      end else if (bus.run) begin
         if (bus.cc_req) begin
            win_valid = 1'b1;
            win_id    = 8'd1;
         end else if (bus.mic_req) begin
            win_valid = 1'b1;
            win_id    = 8'd2;
         end else if (wb_eligible_reg && bus.wb_enable && bus.wb_req) begin
            win_valid = 1'b1;
            win_is_wb = 1'b1;
            win_id    = 8'd3;
         end else if (ddc_found) begin
            win_valid      = 1'b1;
            win_is_ddc     = 1'b1;
            win_id         = 8'd11 + 8'(ddc_k);
            win_ddc[ddc_k] = 1'b1;
         end
      end
   end

   // A non-discovery grant is released as if done when the host clears run.
   assign run_abort = !bus.run && (grant_id_reg != 8'd0);

   // Scheduler state machine, grant registers, round-robin pointer and counters.
   always_ff @(posedge tx_clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg       <= ST_IDLE;
         grant_valid_reg <= 1'b0;
         grant_id_reg    <= 8'd0;
         grant_ddc_reg   <= '0;
         timeout_err_reg <= 1'b0;
         rr_ptr_reg      <= '0;
         wb_eligible_reg <= 1'b0;
         gap_cnt_reg     <= 4'd0;
         wd_cnt_reg      <= 16'd0;
      end else begin
         timeout_err_reg <= 1'b0;
         if (!bus.wb_enable) begin
            wb_eligible_reg <= 1'b0;
         end
         case (state_reg)
            ST_IDLE: begin
               if (bus.wb_enable) begin
                  if (win_is_wb) begin
                     wb_eligible_reg <= 1'b0;
                  end else if (!(|bus.ddc_req) || (win_is_ddc && rr_ptr_next == '0)) begin
                     wb_eligible_reg <= 1'b1;
                  end
               end
               if (win_valid) begin
                  state_reg       <= ST_GRANT;
                  grant_valid_reg <= 1'b1;
                  grant_id_reg    <= win_id;
                  grant_ddc_reg   <= win_ddc;
                  if (win_is_ddc) begin
                     rr_ptr_reg <= rr_ptr_next;
                  end
               end
            end
            ST_GRANT: begin
               wd_cnt_reg <= 16'd0;
               if (run_abort) begin
                  state_reg       <= ST_GAP;
                  grant_valid_reg <= 1'b0;
                  gap_cnt_reg     <= 4'd0;
               end else begin
                  state_reg <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (bus.send_done || run_abort) begin
                  state_reg       <= ST_GAP;
                  grant_valid_reg <= 1'b0;
                  gap_cnt_reg     <= 4'd0;
               end else if (wd_cnt_reg == WD_LAST) begin
                  state_reg       <= ST_GAP;
                  grant_valid_reg <= 1'b0;
                  gap_cnt_reg     <= 4'd0;
                  timeout_err_reg <= 1'b1;
               end else begin
                  wd_cnt_reg <= wd_cnt_reg + 16'd1;
               end
            end
            default: begin
               if (gap_cnt_reg == GAP_LAST) begin
                  state_reg <= ST_IDLE;
               end else begin
                  gap_cnt_reg <= gap_cnt_reg + 4'd1;
               end
            end
         endcase
      end
   end

   assign bus.grant_valid = grant_valid_reg;
   assign bus.grant_id    = grant_id_reg;
   assign bus.grant_ddc   = grant_ddc_reg;
   assign bus.busy        = (state_reg != ST_IDLE);
   assign bus.timeout_err = timeout_err_reg;

endmodule
